// File: rtl/rggen_apb_arbiter_pkg.sv
// Shared constants and helpers for the APB host arbiter and its round-robin core.
package rggen_apb_arbiter_pkg;

    // Largest number of requesters an arbiter instance is expected to serve.
    localparam int RGGEN_MAX_HOSTS = 8;

    // Width of a host index register; a single host still needs one bit.
    function automatic int rggen_index_width(input int hosts);
        return (hosts > 1) ? $clog2(hosts) : 1;
    endfunction

    // Round-robin rank of a candidate: 0 for the host right after the last
    // winner, rising in ascending order with wrap-around.
    function automatic int rggen_rr_distance(
        input int index,
        input int last,
        input int hosts
    );
        return (index - last - 1 + hosts) % hosts;
    endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB signal bundle shared by requesters, the arbiter and the register-block adapter.
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       psel;
    logic                       penable;
    logic [ADDRESS_WIDTH-1:0]   paddr;
    logic                       pwrite;
    logic [BUS_WIDTH-1:0]       pwdata;
    logic [BUS_WIDTH/8-1:0]     pstrb;
    logic                       pready;
    logic [BUS_WIDTH-1:0]       prdata;
    logic                       pslverr;

    modport master (
        output psel,
        output penable,
        output paddr,
        output pwrite,
        output pwdata,
        output pstrb,
        input  pready,
        input  prdata,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  paddr,
        input  pwrite,
        input  pwdata,
        input  pstrb,
        output pready,
        output prdata,
        output pslverr
    );
endinterface

// File: rtl/rggen_round_robin_arbiter.sv
// Generic round-robin arbiter: one-hot grant over the request vector, search
// starting just after the previous winner. Host 0 has top priority after reset.
module rggen_round_robin_arbiter
    import rggen_apb_arbiter_pkg::*;
#(
    parameter int HOSTS = 2
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [HOSTS-1:0]    request,
    input  logic                grant_enable,
    output logic [HOSTS-1:0]    grant
);

    localparam int                      INDEX_WIDTH = rggen_index_width(HOSTS);
    localparam logic [INDEX_WIDTH-1:0]  RESET_INDEX = INDEX_WIDTH'(HOSTS - 1);

    logic [INDEX_WIDTH-1:0] last_grant;
    logic [INDEX_WIDTH-1:0] next_grant;
    int                     best_distance;

    // Pick the requester with the smallest round-robin rank.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant         = '0;
        next_grant    = last_grant;
        best_distance = HOSTS;
        for (int i = 0; i < HOSTS; i++) begin
            if (request[i] &&
                (rggen_rr_distance(i, int'(last_grant), HOSTS) < best_distance)) begin
                best_distance = rggen_rr_distance(i, int'(last_grant), HOSTS);
                next_grant    = INDEX_WIDTH'(i);
                grant         = '0;
                grant[i]      = 1'b1;
            end
        end
    end

    // Remember the winner only when the grant is actually taken.
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= RESET_INDEX;
        end else if (grant_enable && (|grant)) begin
            last_grant <= next_grant;
        end
    end

endmodule

// File: rtl/rggen_apb_arbiter.sv
// Lets several APB requesters share one register-block APB port. One transfer
// per grant; the winner's command is registered and replayed on the device side
// with a fresh SETUP/ACCESS sequence, and the response is routed back to it only.
module rggen_apb_arbiter
    import rggen_apb_arbiter_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    rggen_apb_if.slave      host_if[HOSTS],
    rggen_apb_if.master     device_if
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;

    if ((HOSTS < 1) || (HOSTS > RGGEN_MAX_HOSTS)) begin : g_invalid_hosts
        $error("rggen_apb_arbiter: HOSTS must be within 1..%0d", RGGEN_MAX_HOSTS);
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                     state;
    logic [HOSTS-1:0]           request;
    logic [HOSTS-1:0]           grant;
    logic [HOSTS-1:0]           active_grant;
    logic [HOSTS-1:0]           host_live;
    logic                       grant_enable;
    logic                       granted_psel;
    logic                       response_valid;

    logic [ADDRESS_WIDTH-1:0]   host_paddr  [HOSTS];
    logic [HOSTS-1:0]           host_pwrite;
    logic [BUS_WIDTH-1:0]       host_pwdata [HOSTS];
    logic [STROBE_WIDTH-1:0]    host_pstrb  [HOSTS];

    logic [ADDRESS_WIDTH-1:0]   selected_paddr;
    logic                       selected_pwrite;
    logic [BUS_WIDTH-1:0]       selected_pwdata;
    logic [STROBE_WIDTH-1:0]    selected_pstrb;

    logic                       psel_q;
    logic                       penable_q;
    logic [ADDRESS_WIDTH-1:0]   paddr_q;
    logic                       pwrite_q;
    logic [BUS_WIDTH-1:0]       pwdata_q;
    logic [STROBE_WIDTH-1:0]    pstrb_q;

    // Per-host unpacking of requests and gating of the shared response.
    // A host only sees the response while it is the granted one, still
    // selecting, and the device side is in ACCESS; otherwise everything is 0.
    for (genvar g = 0; g < HOSTS; g++) begin : g_host
        assign request[g]           = host_if[g].psel;
        assign host_paddr[g]        = host_if[g].paddr;
        assign host_pwrite[g]       = host_if[g].pwrite;
        assign host_pwdata[g]       = host_if[g].pwdata;
        assign host_pstrb[g]        = host_if[g].pstrb;

        assign host_live[g]         = active_grant[g] & response_valid & request[g] & penable_q;
        assign host_if[g].pready    = host_live[g] & device_if.pready;
        assign host_if[g].prdata    = host_live[g] ? device_if.prdata : '0;
        assign host_if[g].pslverr   = host_live[g] & device_if.pslverr;
    end

    assign grant_enable = (state == IDLE);
    assign granted_psel = |(active_grant & request);

    rggen_round_robin_arbiter #(
        .HOSTS          (HOSTS)
    ) u_round_robin (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .request        (request),
        .grant_enable   (grant_enable),
        .grant          (grant)
    );

    // AND-OR selection of the winner's command using the one-hot grant.
    always_comb begin
        selected_paddr  = '0;
        selected_pwrite = 1'b0;
        selected_pwdata = '0;
        selected_pstrb  = '0;
        for (int i = 0; i < HOSTS; i++) begin
            selected_paddr  = selected_paddr  | (host_paddr[i]  & {ADDRESS_WIDTH{grant[i]}});
            selected_pwrite = selected_pwrite | (host_pwrite[i] & grant[i]);
            selected_pwdata = selected_pwdata | (host_pwdata[i] & {BUS_WIDTH{grant[i]}});
            selected_pstrb  = selected_pstrb  | (host_pstrb[i]  & {STROBE_WIDTH{grant[i]}});
        end
    end

    // Transfer sequencer: latch the winner's command, then walk SETUP and
    // ACCESS on the device side. A winner that drops psel mid-transfer still
    // gets its device transfer finished, but its response is discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            active_grant    <= '0;
            response_valid  <= 1'b0;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            paddr_q         <= '0;
            pwrite_q        <= 1'b0;
            pwdata_q        <= '0;
            pstrb_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        state           <= SETUP;
                        active_grant    <= grant;
                        response_valid  <= 1'b1;
                        psel_q          <= 1'b1;
                        paddr_q         <= selected_paddr;
                        pwrite_q        <= selected_pwrite;
                        pwdata_q        <= selected_pwdata;
                        pstrb_q         <= selected_pstrb;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    penable_q   <= 1'b1;
                    if (!granted_psel) begin
                        response_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!granted_psel) begin
                        response_valid <= 1'b0;
                    end
                    if (device_if.pready) begin
                        state           <= IDLE;
                        psel_q          <= 1'b0;
                        penable_q       <= 1'b0;
                        active_grant    <= '0;
                        response_valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign device_if.psel       = psel_q;
    assign device_if.penable    = penable_q;
    assign device_if.paddr      = paddr_q;
    assign device_if.pwrite     = pwrite_q;
    assign device_if.pwdata     = pwdata_q;
    assign device_if.pstrb      = pstrb_q;

endmodule
